div: RTL

DIV -- requirements
Module: div

---
 rtl/div.sv | 121 ++++++++++++
 1 files changed

// File: rtl/div.sv
// Iterative 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Optional macro DIV_EARLY_EXIT_EN short-circuits operations where |dividend| < |divisor|.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] rem, quo, dvs;
    logic        neg_q, neg_r;

    logic        op1_neg, op2_neg;
    logic [31:0] abs1, abs2;
    logic        accept, div_zero, early;
    logic [32:0] trial, diff;
    logic [31:0] q_fix, r_fix;

    assign op1_neg  = signed_div_i & opdata1_i[31];
    assign op2_neg  = signed_div_i & opdata2_i[31];
    assign abs1     = op1_neg ? (32'd0 - opdata1_i) : opdata1_i;
    assign abs2     = op2_neg ? (32'd0 - opdata2_i) : opdata2_i;
    assign accept   = (state == FREE) & start_i & ~annul_i;
    assign div_zero = (opdata2_i == 32'd0);

`ifdef DIV_EARLY_EXIT_EN
    assign early = (abs1 < abs2);
`else
    assign early = 1'b0;
`endif

    // Shifted partial remainder needs a 33rd bit; a non-negative difference always fits in 32.
    assign trial = {rem, quo[31]};
    assign diff  = trial - {1'b0, dvs};
    assign q_fix = neg_q ? (32'd0 - quo) : quo;
    assign r_fix = neg_r ? (32'd0 - rem) : rem;

    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (accept) state_nxt = (div_zero || early) ? BYZERO : ON;
            end
            // Short path waits one extra cycle so its result timing matches a registered finish.
            BYZERO: begin
                if (annul_i)            state_nxt = FREE;
                else if (cnt != 6'd0)   state_nxt = END;
            end
            ON: begin
                if (annul_i || !start_i) state_nxt = FREE;
                else if (cnt == 6'd32)   state_nxt = END;
            end
            END: begin
                if (annul_i || !start_i) state_nxt = FREE;
            end
            default: state_nxt = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 6'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            dvs      <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_o <= (state_nxt == END);

            if (state_nxt == FREE)
                result_o <= 64'd0;
            else if (state_nxt == END && state != END)
                result_o <= (state == ON) ? {r_fix, q_fix} : {rem, quo};

            case (state)
                FREE: begin
                    if (accept) begin
                        neg_q <= op1_neg ^ op2_neg;
                        neg_r <= op1_neg;
                        dvs   <= abs2;
                        cnt   <= 6'd0;
                        if (div_zero) begin
                            rem <= 32'd0;
                            quo <= 32'd0;
                        end else if (early) begin
                            rem <= opdata1_i;
                            quo <= 32'd0;
                        end else begin
                            rem <= 32'd0;
                            quo <= abs1;
                        end
                    end
                end
                BYZERO: cnt <= cnt + 6'd1;
                ON: begin
                    if (cnt != 6'd32) begin
                        cnt <= cnt + 6'd1;
                        quo <= {quo[30:0], ~diff[32]};
                        rem <= diff[32] ? trial[31:0] : diff[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
